// File: rtl/md5_search.sv
// Brute-force MD5 searcher over an inclusive range of 8-digit BCD candidates.
// Each candidate is hashed by an iterative core doing one MD5 step per cycle.
module md5_search (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [31:0]  low,
   input  logic [31:0]  high,
   input  logic [127:0] hash,
   output logic         done,
   output logic         found,
   output logic [31:0]  pass
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_CHECK, S_DONE} state_t;

   localparam logic [31:0] IV_A = 32'h67452301;
   localparam logic [31:0] IV_B = 32'hefcdab89;
   localparam logic [31:0] IV_C = 32'h98badcfe;
   localparam logic [31:0] IV_D = 32'h10325476;

   state_t        state, state_nx;
   logic [31:0]   cand, high_q, m0, m1;
   logic [127:0]  hash_q;
   logic [31:0]   a, b, c, d;
   logic [5:0]    rnd;

   logic [31:0]   fv, kv, mv, tmp, rot, cand_inc;
   logic [3:0]    gi, r4;
   logic [4:0]    sft;
   logic [127:0]  digest;
   logic          match;

   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic logic [31:0] bcd_inc(input logic [31:0] v);
      logic [31:0] r;
      logic        cy;
      r  = v;
      cy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (cy) begin
            if (r[4*i +: 4] >= 4'd9) r[4*i +: 4] = 4'd0;
            else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               cy = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Round function and message schedule for the current step
   always_comb begin
      r4 = rnd[3:0];
      fv = '0;
      gi = '0;
      case (rnd[5:4])
         2'd0: begin fv = (b & c) | (~b & d); gi = r4; end
         2'd1: begin fv = (d & b) | (~d & c); gi = r4 * 4'd5 + 4'd1; end
         2'd2: begin fv = b ^ c ^ d;          gi = r4 * 4'd3 + 4'd5; end
         default: begin fv = c ^ (b | ~d);    gi = r4 * 4'd7; end
      endcase
      case (gi)
         4'd0:    mv = m0;
         4'd1:    mv = m1;
         4'd2:    mv = 32'h00000080;
         4'd14:   mv = 32'h00000040;
         default: mv = 32'h00000000;
      endcase
   end

   always_comb begin
      case ({rnd[5:4], rnd[1:0]})
         4'h0: sft = 5'd7;  4'h1: sft = 5'd12; 4'h2: sft = 5'd17; 4'h3: sft = 5'd22;
         4'h4: sft = 5'd5;  4'h5: sft = 5'd9;  4'h6: sft = 5'd14; 4'h7: sft = 5'd20;
         4'h8: sft = 5'd4;  4'h9: sft = 5'd11; 4'hA: sft = 5'd16; 4'hB: sft = 5'd23;
         4'hC: sft = 5'd6;  4'hD: sft = 5'd10; 4'hE: sft = 5'd15; default: sft = 5'd21;
      endcase
   end

   always_comb begin
      case (rnd)
         6'd0:  kv = 32'hd76aa478; 6'd1:  kv = 32'he8c7b756; 6'd2:  kv = 32'h242070db; 6'd3:  kv = 32'hc1bdceee;
         6'd4:  kv = 32'hf57c0faf; 6'd5:  kv = 32'h4787c62a; 6'd6:  kv = 32'ha8304613; 6'd7:  kv = 32'hfd469501;
         6'd8:  kv = 32'h698098d8; 6'd9:  kv = 32'h8b44f7af; 6'd10: kv = 32'hffff5bb1; 6'd11: kv = 32'h895cd7be;
         6'd12: kv = 32'h6b901122; 6'd13: kv = 32'hfd987193; 6'd14: kv = 32'ha679438e; 6'd15: kv = 32'h49b40821;
         6'd16: kv = 32'hf61e2562; 6'd17: kv = 32'hc040b340; 6'd18: kv = 32'h265e5a51; 6'd19: kv = 32'he9b6c7aa;
         6'd20: kv = 32'hd62f105d; 6'd21: kv = 32'h02441453; 6'd22: kv = 32'hd8a1e681; 6'd23: kv = 32'he7d3fbc8;
         6'd24: kv = 32'h21e1cde6; 6'd25: kv = 32'hc33707d6; 6'd26: kv = 32'hf4d50d87; 6'd27: kv = 32'h455a14ed;
         6'd28: kv = 32'ha9e3e905; 6'd29: kv = 32'hfcefa3f8; 6'd30: kv = 32'h676f02d9; 6'd31: kv = 32'h8d2a4c8a;
         6'd32: kv = 32'hfffa3942; 6'd33: kv = 32'h8771f681; 6'd34: kv = 32'h6d9d6122; 6'd35: kv = 32'hfde5380c;
         6'd36: kv = 32'ha4beea44; 6'd37: kv = 32'h4bdecfa9; 6'd38: kv = 32'hf6bb4b60; 6'd39: kv = 32'hbebfbc70;
         6'd40: kv = 32'h289b7ec6; 6'd41: kv = 32'heaa127fa; 6'd42: kv = 32'hd4ef3085; 6'd43: kv = 32'h04881d05;
         6'd44: kv = 32'hd9d4d039; 6'd45: kv = 32'he6db99e5; 6'd46: kv = 32'h1fa27cf8; 6'd47: kv = 32'hc4ac5665;
         6'd48: kv = 32'hf4292244; 6'd49: kv = 32'h432aff97; 6'd50: kv = 32'hab9423a7; 6'd51: kv = 32'hfc93a039;
         6'd52: kv = 32'h655b59c3; 6'd53: kv = 32'h8f0ccc92; 6'd54: kv = 32'hffeff47d; 6'd55: kv = 32'h85845dd1;
         6'd56: kv = 32'h6fa87e4f; 6'd57: kv = 32'hfe2ce6e0; 6'd58: kv = 32'ha3014314; 6'd59: kv = 32'h4e0811a1;
         6'd60: kv = 32'hf7537e82; 6'd61: kv = 32'hbd3af235; 6'd62: kv = 32'h2ad7d2bb; default: kv = 32'heb86d391;
      endcase
   end

   // sft is never zero, so the right shift never reaches 32
   always_comb begin
      tmp      = a + fv + kv + mv;
      rot      = (tmp << sft) | (tmp >> (6'd32 - {1'b0, sft}));
      digest   = {bswap(a + IV_A), bswap(b + IV_B), bswap(c + IV_C), bswap(d + IV_D)};
      match    = (digest == hash_q);
      cand_inc = bcd_inc(cand);
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = (low > high) ? S_DONE : S_LOAD;
         S_LOAD:  state_nx = S_ROUND;
         S_ROUND: if (rnd == 6'd63) state_nx = S_CHECK;
         S_CHECK: state_nx = (match || cand == high_q) ? S_DONE : S_LOAD;
         S_DONE:  if (!start) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         cand   <= '0;
         high_q <= '0;
         hash_q <= '0;
         m0     <= '0;
         m1     <= '0;
         a      <= '0;
         b      <= '0;
         c      <= '0;
         d      <= '0;
         rnd    <= '0;
         done   <= 1'b0;
         found  <= 1'b0;
         pass   <= '0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: if (start) begin
               cand   <= low;
               high_q <= high;
               hash_q <= hash;
               if (low > high) begin
                  done  <= 1'b1;
                  found <= 1'b0;
                  pass  <= high;
               end
            end
            S_LOAD: begin
               a   <= IV_A;
               b   <= IV_B;
               c   <= IV_C;
               d   <= IV_D;
               // ASCII digits, most significant digit in the lowest byte
               m0  <= {4'h3, cand[19:16], 4'h3, cand[23:20], 4'h3, cand[27:24], 4'h3, cand[31:28]};
               m1  <= {4'h3, cand[3:0],   4'h3, cand[7:4],   4'h3, cand[11:8],  4'h3, cand[15:12]};
               rnd <= '0;
            end
            S_ROUND: begin
               a   <= d;
               b   <= b + rot;
               c   <= b;
               d   <= c;
               rnd <= rnd + 6'd1;
            end
            S_CHECK: begin
               if (match) begin
                  done  <= 1'b1;
                  found <= 1'b1;
                  pass  <= cand;
               end else if (cand == high_q) begin
                  done  <= 1'b1;
                  found <= 1'b0;
                  pass  <= high_q;
               end else begin
                  cand <= cand_inc;
               end
            end
            S_DONE: if (!start) begin
               done  <= 1'b0;
               found <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
